// File: rtl/lock_guard_ctrl.sv
// lock_guard_ctrl: supervisory controller for the digital lock.
//
// Sequences the lock through LOCKED, OPEN and LOCKOUT from per-entry code
// check results, enforces a retry limit with a timed lockout, auto-relocks
// after an open window and gates password-change requests.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   check_valid     1-cycle pulse: entry FSM finished a code check
//   check_match     qualified by check_valid; 1 = code correct
//   relock          1-cycle pulse: user closes the lock early
//   change_req      1-cycle pulse: user requests a password change
//   accept          1 = LOCKED; entry FSM may start a new entry
//   unlocked        1 = OPEN
//   pw_change_grant 1-cycle pulse: password register may load a new value
//   tries_left      MAX_TRIES minus current fail count
//   secs_left       remaining seconds in OPEN/LOCKOUT, else 0
//   led             [5]=unlocked, [4]=lockout AND blink, [3:0]=tries_left
//   ssd             four 5-bit symbol codes, MSB digit first
module lock_guard_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCKOUT_SEC = 10,
  parameter int unsigned OPEN_SEC    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        check_valid,
  input  logic        check_match,
  input  logic        relock,
  input  logic        change_req,
  output logic        accept,
  output logic        unlocked,
  output logic        pw_change_grant,
  output logic [3:0]  tries_left,
  output logic [7:0]  secs_left,
  output logic [5:0]  led,
  output logic [19:0] ssd
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PreMax   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PreHalf  = PW'(TICK_DIV / 2);
  localparam logic [3:0]    LastTry  = 4'(MAX_TRIES - 1);
  localparam logic [3:0]    MaxTries = 4'(MAX_TRIES);
  localparam logic [7:0]    OpenSec  = 8'(OPEN_SEC);
  localparam logic [7:0]    LockSec  = 8'(LOCKOUT_SEC);

  // Symbol codes understood by the binary-to-segment stage.
  localparam logic [4:0] SymE     = 5'b01110;
  localparam logic [4:0] SymC     = 5'b01100;
  localparam logic [4:0] SymBlank = 5'b10000;
  localparam logic [4:0] SymL     = 5'b10001;
  localparam logic [4:0] SymD     = 5'b10010;
  localparam logic [4:0] SymP     = 5'b10011;
  localparam logic [4:0] SymN     = 5'b10100;
  localparam logic [4:0] Sym0     = 5'b00000;
  localparam logic [4:0] Sym5     = 5'b00101;

  typedef enum logic [1:0] {StLocked, StOpen, StLockout} state_e;

  state_e        state_q, state_d;
  logic [3:0]    fail_cnt_q, fail_cnt_d;
  logic [7:0]    timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          grant_q, grant_d;

  logic tick, blink, expire;
  logic [7:0] tens, units;

  assign tick   = (presc_q == PreMax);
  assign blink  = (presc_q < PreHalf);
  assign expire = tick && (timer_q == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLocked;
      fail_cnt_q <= 4'd0;
      timer_q    <= 8'd0;
      presc_q    <= '0;
      grant_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      grant_q    <= grant_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    grant_d    = 1'b0;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    unique case (state_q)
      StLocked: begin
        if (check_valid) begin
          if (check_match) begin
            state_d    = StOpen;
            timer_d    = OpenSec;
            fail_cnt_d = 4'd0;
            presc_d    = '0;
          end else if (fail_cnt_q == LastTry) begin
            state_d    = StLockout;
            timer_d    = LockSec;
            fail_cnt_d = 4'd0;
            presc_d    = '0;
          end else begin
            fail_cnt_d = fail_cnt_q + 4'd1;
          end
        end
      end
      StOpen: begin
        if (relock || expire) begin
          state_d = StLocked;
          timer_d = 8'd0;
        end else if (change_req) begin
          // Granting a change restarts the full open window.
          grant_d = 1'b1;
          timer_d = OpenSec;
          presc_d = '0;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      StLockout: begin
        if (expire) begin
          state_d = StLocked;
          timer_d = 8'd0;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin
        state_d = StLocked;
        timer_d = 8'd0;
      end
    endcase
  end

  assign tens  = timer_q / 8'd10;
  assign units = timer_q % 8'd10;

  assign accept          = (state_q == StLocked);
  assign unlocked        = (state_q == StOpen);
  assign pw_change_grant = grant_q;
  assign tries_left      = MaxTries - fail_cnt_q;
  assign secs_left       = timer_q;
  assign led             = {unlocked, (state_q == StLockout) && blink, tries_left};

  always_comb begin
    ssd = {SymC, SymL, Sym5, SymD};
    unique case (state_q)
      StLocked:  ssd = {SymC, SymL, Sym5, SymD};
      StOpen:    ssd = {Sym0, SymP, SymE, SymN};
      StLockout: begin
        if (blink) ssd = {SymL, SymBlank, tens[4:0], units[4:0]};
        else       ssd = {SymL, SymBlank, SymBlank, SymBlank};
      end
      default:   ssd = {SymC, SymL, Sym5, SymD};
    endcase
  end

endmodule

// File: tb/tb_lock_guard_ctrl.sv
// Scoreboard bench for lock_guard_ctrl: a driver issues one input vector per
// cycle, advances a window-based reference model and queues the expected
// outputs; a monitor pops and compares after every active edge.
module tb_lock_guard_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned MT = 3;
  localparam int unsigned LS = 3;
  localparam int unsigned OS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        check_valid = 1'b0;
  logic        check_match = 1'b0;
  logic        relock = 1'b0;
  logic        change_req = 1'b0;
  logic        accept, unlocked, pw_change_grant;
  logic [3:0]  tries_left;
  logic [7:0]  secs_left;
  logic [5:0]  led;
  logic [19:0] ssd;

  lock_guard_ctrl #(
    .TICK_DIV   (TD),
    .MAX_TRIES  (MT),
    .LOCKOUT_SEC(LS),
    .OPEN_SEC   (OS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .check_valid    (check_valid),
    .check_match    (check_match),
    .relock         (relock),
    .change_req     (change_req),
    .accept         (accept),
    .unlocked       (unlocked),
    .pw_change_grant(pw_change_grant),
    .tries_left     (tries_left),
    .secs_left      (secs_left),
    .led            (led),
    .ssd            (ssd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        accept;
    logic        unlocked;
    logic        grant;
    logic [3:0]  tries;
    logic [7:0]  secs;
    logic [5:0]  led;
    logic [19:0] ssd;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=locked, 1=open, 2=lockout. A timed window is
  // described by its length in seconds and the cycles elapsed since it began.
  int m_mode  = 0;
  int m_fails = 0;
  int m_len   = 0;
  int m_cyc   = 0;
  bit m_grant = 0;

  function automatic void model_edge(bit r, bit v, bit m, bit rl, bit cr);
    bit last;
    last = (m_cyc + 1 == m_len * int'(TD));
    m_grant = 0;
    if (r) begin
      m_mode = 0; m_fails = 0;
    end else if (m_mode == 0) begin
      if (v && m) begin
        m_mode = 1; m_len = OS; m_cyc = 0; m_fails = 0;
      end else if (v) begin
        if (m_fails + 1 == int'(MT)) begin
          m_mode = 2; m_len = LS; m_cyc = 0; m_fails = 0;
        end else begin
          m_fails++;
        end
      end
    end else if (m_mode == 1) begin
      if (rl || last) m_mode = 0;
      else if (cr) begin m_cyc = 0; m_grant = 1; end
      else m_cyc++;
    end else begin
      if (last) m_mode = 0;
      else m_cyc++;
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int secs;
    bit blink;
    secs  = (m_mode == 0) ? 0 : m_len - m_cyc / int'(TD);
    blink = (m_cyc % int'(TD)) < int'(TD / 2);
    e.accept   = (m_mode == 0);
    e.unlocked = (m_mode == 1);
    e.grant    = m_grant;
    e.tries    = 4'(int'(MT) - m_fails);
    e.secs     = 8'(secs);
    e.led      = {e.unlocked, (m_mode == 2) && blink, e.tries};
    if (m_mode == 0)  e.ssd = {5'd12, 5'd17, 5'd5, 5'd18};
    else if (m_mode == 1) e.ssd = {5'd0, 5'd19, 5'd14, 5'd20};
    else if (blink)   e.ssd = {5'd17, 5'd16, 5'(secs / 10), 5'(secs % 10)};
    else              e.ssd = {5'd17, 5'd16, 5'd16, 5'd16};
    return e;
  endfunction

  task automatic step(input bit r, input bit v, input bit m, input bit rl, input bit cr);
    @(negedge clk);
    rst = r; check_valid = v; check_match = m; relock = rl; change_req = cr;
    model_edge(r, v, m, rl, cr);
    sb_q.push_back(predict());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("accept", int'(accept), int'(e.accept));
        chk("unlocked", int'(unlocked), int'(e.unlocked));
        chk("pw_change_grant", int'(pw_change_grant), int'(e.grant));
        chk("tries_left", int'(tries_left), int'(e.tries));
        chk("secs_left", int'(secs_left), int'(e.secs));
        chk("led", int'(led), int'(e.led));
        chk("ssd", int'(ssd), int'(e.ssd));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // Open window and auto-relock.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle(9);
    // Three misses into lockout; a match during lockout is dropped.
    step(0, 1, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle(13);
    // change_req near the end of the window, then while locked.
    step(0, 1, 1, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    idle(9);
    step(0, 0, 0, 0, 1);
    idle(2);
    // relock beats change_req; fail count cleared by a match.
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0);
    idle(2);
    // Reset mid-lockout.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0);
    idle(3);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) == 0), $urandom_range(1) == 1,
           ($urandom_range(15) == 0), ($urandom_range(7) == 0));
    end
    step(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
